// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings
// plus the sign-magnitude helper used when an operation is accepted.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_e;

    function automatic logic [MD_WIDTH-1:0] to_mag(input logic [MD_WIDTH-1:0] v,
                                                   input logic                is_signed);
        return (is_signed && v[MD_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one bit per cycle on a
// shared 2*WIDTH accumulator, signs applied when the result is committed.
module muldiv_hilo
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               sgn_q, sgn_d;
    logic               rsgn_q, rsgn_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               is_sig;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        rsgn_d   = rsgn_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        is_sig = ~op[0];
        ma     = to_mag(a, is_sig);
        mb     = to_mag(b, is_sig);

        // Multiply: add multiplicand into the upper half, shift right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
        // Divide: shift next dividend bit into the partial remainder, trial subtract.
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opd_q};

        prod = sgn_q  ? -acc_q : acc_q;
        quot = sgn_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rsgn_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    a_d      = a;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? ma : mb)};
                    opd_d    = op[1] ? mb : ma;
                    sgn_d    = is_sig & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rsgn_d   = is_sig & a[WIDTH-1];
                    dz_d     = (b == '0);
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            rsgn_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            rsgn_q   <= rsgn_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: directed and random ops against a plain-arithmetic
// model of MIPS MULT/MULTU/DIV/DIVU, plus timing, MTHI/MTLO and reset cases.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint      p, q, r;
        logic [63:0] pu;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {mh, ml} = p;
            end
            2'b01: begin
                pu = {32'b0, x} * {32'b0, y};
                {mh, ml} = pu;
            end
            2'b10: begin
                if (y == 0) begin
                    mh = x; ml = 32'hFFFF_FFFF;
                end else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    ml = q[31:0]; mh = r[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    mh = x; ml = 32'hFFFF_FFFF;
                end else begin
                    ml = x / y; mh = x % y;
                end
            end
        endcase
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
        int          cyc, bc;
        logic        stable;
        logic [31:0] eh, el;
        model(o, x, y, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        // Scramble operands after acceptance; the unit must have latched them.
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        cyc = 0;
        bc = busy ? 1 : 0;
        stable = 1'b1;
        while (!done && cyc < 40) begin
            if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (busy) bc++;
        end
        chk({tag, "_latency"}, cyc, 33);
        chk({tag, "_busy_cycles"}, bc, 32);
        chk({tag, "_hilo_stable"}, {31'b0, stable}, 1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    initial begin
        int          cyc;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #12;
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        @(negedge clk); rst = 1'b0;

        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        do_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        do_op(2'b10, 32'd5, 32'd0, "div_by0");
        do_op(2'b11, 32'd5, 32'd0, "divu_by0");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");

        // start and mthi during RUN are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 4);
            if (i == 4) a = 32'd9;
            mthi  = (i == 9);
            if (i == 9) wdata = 32'hAA;
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0; mthi = 1'b0;
        chk("ignore_latency", cyc, 33);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd12);
        @(posedge clk); #1;
        chk("ignore_not_restarted", {31'b0, busy}, 0);

        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h55);
        chk("mtlo_hi", hi, 32'h0);
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        m_hi = 32'h1234_5678;
        m_lo = 32'h55;

        // async reset mid-divide
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_reset_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk); rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        do_op(2'b11, 32'd100, 32'd7, "after_rst");

        for (int n = 0; n < 16; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (n % 5 == 4) ? 32'd0 : $urandom;
            if (n % 3 == 1) rb = rb >> $urandom_range(8, 28);
            do_op(ro, ra, rb, $sformatf("rand%0d_op%0d", n, ro));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
